// File: rtl/spiral_pkg.sv
// rtl/spiral_pkg.sv - shared state encoding and command/speed codes for the spiral planner
// Constants are 32 bits wide; users slice them to their own port widths.
package spiral_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_ARC,
    ST_LEG,
    ST_TURN,
    ST_DONE
  } state_t;

  localparam logic [31:0] RADIUS_STRAIGHT = 32'hFFFF_FFFF;
  localparam logic [31:0] RADIUS_SPIN     = 32'd1;
  localparam logic [31:0] SPEED_STOP      = 32'd0;
  localparam logic [31:0] SPEED_SPIN      = 32'd1;

endpackage

// File: rtl/spiral_seg_timer.sv
// rtl/spiral_seg_timer.sv - loadable down-counter timing one arc or leg segment
// expire is high during the last cycle of a loaded duration.
module spiral_seg_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == W'(1));

endmodule

// File: rtl/spiral_planner.sv
// rtl/spiral_planner.sv - expanding circular/square spiral trajectory generator
// Optional bump-abort input/output guarded by SPIRAL_BUMP_EN.
module spiral_planner
  import spiral_pkg::*;
#(
  parameter int SPEED_W      = 3,
  parameter int CMD_W        = 10,
  parameter int NUM_RINGS    = 3,
  parameter int BASE_CYCLES  = 4,
  parameter int RADIUS_START = 100,
  parameter int RADIUS_STEP  = 50
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               mode,
  input  logic               done_spin,
  output logic [SPEED_W-1:0] output_speed,
  output logic [CMD_W-1:0]   motion_command,
  output logic               busy,
  output logic               done
`ifdef SPIRAL_BUMP_EN
  ,
  input  logic               bump,
  output logic               bump_abort
`endif
);

  localparam int TW         = $clog2(BASE_CYCLES * NUM_RINGS + 1);
  localparam int LW         = $clog2(2 * NUM_RINGS + 1);
  localparam int RADIUS_MAX = (1 << CMD_W) - 2;
  localparam int SPEED_MAX  = (1 << SPEED_W) - 1;
  localparam logic [LW-1:0]      RINGS_L      = LW'(NUM_RINGS);
  localparam logic [LW-1:0]      LEGS_L       = LW'(2 * NUM_RINGS);
  localparam logic [CMD_W-1:0]   CMD_STRAIGHT = RADIUS_STRAIGHT[CMD_W-1:0];
  localparam logic [CMD_W-1:0]   CMD_SPIN     = RADIUS_SPIN[CMD_W-1:0];
  localparam logic [SPEED_W-1:0] SPD_STOP     = SPEED_STOP[SPEED_W-1:0];
  localparam logic [SPEED_W-1:0] SPD_SPIN     = SPEED_SPIN[SPEED_W-1:0];

  function automatic logic [SPEED_W-1:0] ring_speed(input logic [LW-1:0] ring);
    int s;
    s = int'(ring) + 1;
    if (s > SPEED_MAX) s = SPEED_MAX;
    return SPEED_W'(s);
  endfunction

  function automatic logic [TW-1:0] ring_cycles(input logic [LW-1:0] ring);
    return TW'(BASE_CYCLES * (int'(ring) + 1));
  endfunction

  // Top code is reserved for STRAIGHT, so radii clip one below it.
  function automatic logic [CMD_W-1:0] sat_radius(input int r);
    return CMD_W'((r > RADIUS_MAX) ? RADIUS_MAX : r);
  endfunction

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic [LW-1:0]      idx_q, idx_d;
  logic [CMD_W-1:0]   radius_q, radius_d;
  logic               done_spin_q;
  logic [SPEED_W-1:0] output_speed_q, output_speed_d;
  logic [CMD_W-1:0]   motion_command_q, motion_command_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               spin_edge;
  logic               bump_hit;
  logic               tmr_load;
  logic [TW-1:0]      tmr_val;
  logic               tmr_clr;
  logic               tmr_expire;

`ifdef SPIRAL_BUMP_EN
  logic bump_abort_q, bump_abort_d;
  assign bump_hit   = bump;
  assign bump_abort = bump_abort_q;
`else
  assign bump_hit = 1'b0;
`endif

  assign spin_edge = done_spin & ~done_spin_q;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    idx_d    = idx_q;
    radius_d = radius_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (state_q inside {ST_ALIGN, ST_ARC, ST_LEG, ST_TURN} && !enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            mode_d  = mode;
            state_d = ST_ALIGN;
          end
        end
        ST_ALIGN: begin
          if (spin_edge) begin
            idx_d    = '0;
            tmr_load = 1'b1;
            tmr_val  = ring_cycles('0);
            if (mode_q) begin
              state_d = ST_LEG;
            end else begin
              state_d  = ST_ARC;
              radius_d = sat_radius(RADIUS_START);
            end
          end
        end
        ST_ARC: begin
          if (bump_hit) begin
            state_d = ST_DONE;
          end else if (tmr_expire) begin
            idx_d = idx_q + LW'(1);
            if (idx_d == RINGS_L) begin
              state_d = ST_DONE;
            end else begin
              radius_d = sat_radius(int'(radius_q) + RADIUS_STEP);
              tmr_load = 1'b1;
              tmr_val  = ring_cycles(idx_d);
            end
          end
        end
        ST_LEG: begin
          if (bump_hit) begin
            state_d = ST_DONE;
          end else if (tmr_expire) begin
            state_d = ST_TURN;
          end
        end
        ST_TURN: begin
          if (spin_edge) begin
            idx_d = idx_q + LW'(1);
            if (idx_d == LEGS_L) begin
              state_d = ST_DONE;
            end else begin
              state_d  = ST_LEG;
              tmr_load = 1'b1;
              tmr_val  = ring_cycles(idx_d >> 1);
            end
          end
        end
        ST_DONE: begin
          if (!enable) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (state_d == ST_IDLE) begin
      idx_d    = '0;
      radius_d = '0;
    end

    // Outputs are registered images of the next state.
    output_speed_d   = SPD_STOP;
    motion_command_d = '0;
    case (state_d)
      ST_ALIGN, ST_TURN: begin
        output_speed_d   = SPD_SPIN;
        motion_command_d = CMD_SPIN;
      end
      ST_ARC: begin
        output_speed_d   = ring_speed(idx_d);
        motion_command_d = radius_d;
      end
      ST_LEG: begin
        output_speed_d   = ring_speed(idx_d >> 1);
        motion_command_d = CMD_STRAIGHT;
      end
      default: ;
    endcase
    busy_d = (state_d inside {ST_ALIGN, ST_ARC, ST_LEG, ST_TURN});
    done_d = (state_d == ST_DONE);
`ifdef SPIRAL_BUMP_EN
    bump_abort_d = bump_abort_q;
    if (state_q inside {ST_ARC, ST_LEG} && enable && bump) bump_abort_d = 1'b1;
    if (state_d != ST_DONE) bump_abort_d = 1'b0;
`endif
  end

  assign tmr_clr = !(state_d inside {ST_ARC, ST_LEG});

  spiral_seg_timer #(
    .W(TW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .load    (tmr_load),
    .load_val(tmr_val),
    .expire  (tmr_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      mode_q           <= 1'b0;
      idx_q            <= '0;
      radius_q         <= '0;
      done_spin_q      <= 1'b0;
      output_speed_q   <= '0;
      motion_command_q <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
`ifdef SPIRAL_BUMP_EN
      bump_abort_q     <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      mode_q           <= mode_d;
      idx_q            <= idx_d;
      radius_q         <= radius_d;
      done_spin_q      <= done_spin;
      output_speed_q   <= output_speed_d;
      motion_command_q <= motion_command_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
`ifdef SPIRAL_BUMP_EN
      bump_abort_q     <= bump_abort_d;
`endif
    end
  end

  assign output_speed   = output_speed_q;
  assign motion_command = motion_command_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_spiral_planner.sv
// tb/tb_spiral_planner.sv - randomized trajectory bench against a segment-list model
module tb_spiral_planner;

  localparam int N = 3;
  localparam int B = 4;
  localparam int RMAX = 1022;

  logic       clk = 1'b0;
  logic       rst, enable, mode, done_spin;
  logic [2:0] spd, spd_s;
  logic [9:0] cmd, cmd_s;
  logic       busy, busy_s, done, done_s;
`ifdef SPIRAL_BUMP_EN
  logic       bump, ba, ba_s;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spiral_planner u_dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .done_spin(done_spin),
    .output_speed(spd), .motion_command(cmd), .busy(busy), .done(done)
`ifdef SPIRAL_BUMP_EN
    , .bump(bump), .bump_abort(ba)
`endif
  );

  spiral_planner #(.NUM_RINGS(2), .RADIUS_START(1000), .RADIUS_STEP(50)) u_sat (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .done_spin(done_spin),
    .output_speed(spd_s), .motion_command(cmd_s), .busy(busy_s), .done(done_s)
`ifdef SPIRAL_BUMP_EN
    , .bump(bump), .bump_abort(ba_s)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_rad(input int start, input int step, input int k);
    int r;
    r = start + step * k;
    return (r > RMAX) ? RMAX : r;
  endfunction

  function automatic int exp_spd(input int ring);
    return (ring + 1 > 7) ? 7 : ring + 1;
  endfunction

  // Saturating instance: 2 rings of 4 and 8 cycles, then DONE.
  function automatic int exp_sat(input int t);
    if (t <= B) return exp_rad(1000, 50, 0);
    if (t <= 3 * B) return exp_rad(1000, 50, 1);
    return 0;
  endfunction

  task automatic pulse_spin();
    done_spin = 1'b1;
    tick();
    done_spin = 1'b0;
  endtask

  task automatic chk_spin(input string tag);
    chk({tag, "_cmd"}, cmd, 1);
    chk({tag, "_spd"}, spd, 1);
    chk({tag, "_busy"}, busy, 1);
  endtask

  task automatic chk_done_exit();
    chk("done_flag", done, 1);
    chk("done_spd", spd, 0);
    chk("done_cmd", cmd, 0);
    chk("done_busy", busy, 0);
    tick();
    chk("done_hold", done, 1);
    enable = 1'b0;
    tick();
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  task automatic run(input logic m, input int abort_ring, input int abort_cyc, input bit hold);
    int t;
    mode = m;
    if (hold) done_spin = 1'b1;
    enable = 1'b1;
    tick();
    mode = ~m;
    chk_spin("align");
    if (hold) begin
      repeat (3) begin
        tick();
        chk_spin("hold");
      end
      done_spin = 1'b0;
      tick();
      chk_spin("hold_low");
    end
    repeat ($urandom_range(0, 3)) begin
      tick();
      chk_spin("align_wait");
    end
    pulse_spin();
    t = 0;
    if (m == 1'b0) begin
      for (int k = 0; k < N; k++) begin
        for (int c = 1; c <= B * (k + 1); c++) begin
          t++;
          chk("arc_cmd", cmd, exp_rad(100, 50, k));
          chk("arc_spd", spd, exp_spd(k));
          chk("arc_busy", busy, 1);
          chk("sat_cmd", cmd_s, exp_sat(t));
          if (k == abort_ring && c == abort_cyc) begin
            enable = 1'b0;
            tick();
            chk("abort_spd", spd, 0);
            chk("abort_cmd", cmd, 0);
            chk("abort_busy", busy, 0);
            chk("abort_done", done, 0);
            return;
          end
          tick();
        end
      end
    end else begin
      for (int l = 0; l < 2 * N; l++) begin
        for (int c = 1; c <= B * (l / 2 + 1); c++) begin
          chk("leg_cmd", cmd, 1023);
          chk("leg_spd", spd, exp_spd(l / 2));
          chk("leg_busy", busy, 1);
          tick();
        end
        chk_spin("turn");
        repeat ($urandom_range(0, 3)) begin
          tick();
          chk_spin("turn_wait");
        end
        pulse_spin();
      end
    end
    chk_done_exit();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    mode = 1'b0;
    done_spin = 1'b0;
`ifdef SPIRAL_BUMP_EN
    bump = 1'b0;
`endif
    repeat (3) tick();
    chk("rst_spd", spd, 0);
    chk("rst_cmd", cmd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    tick();

    run(1'b0, -1, 0, 1'b0);
    run(1'b1, -1, 0, 1'b0);
    run(1'b0, -1, 0, 1'b1);
    run(1'b0, 1, $urandom_range(1, 2 * B), 1'b0);
    run(1'b0, -1, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(0, 1) == 0) run(1'b1, -1, 0, 1'b0);
      else run(1'b0, $urandom_range(0, N), $urandom_range(1, B), 1'b0);
      repeat ($urandom_range(0, 2)) tick();
    end

    // Reset mid-run behaves like power-up.
    mode = 1'b0;
    enable = 1'b1;
    tick();
    pulse_spin();
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_spd", spd, 0);
    chk("midrst_cmd", cmd, 0);
    chk("midrst_busy", busy, 0);
    rst = 1'b0;
    enable = 1'b0;
    tick();

`ifdef SPIRAL_BUMP_EN
    mode = 1'b1;
    enable = 1'b1;
    tick();
    pulse_spin();
    tick();
    bump = 1'b1;
    tick();
    bump = 1'b0;
    chk("bump_done", done, 1);
    chk("bump_abort", ba, 1);
    chk("bump_spd", spd, 0);
    enable = 1'b0;
    tick();
    chk("bump_clear", ba, 0);
    chk("bump_idle", done, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
